// File: rtl/dp_ram_arbiter.sv
// Two-requester front end for one dp_ram: independent round-robin on the read
// and write ports, init blackout, read/write collision deferral, response routing.
module dp_ram_arbiter #(
    parameter int ADDR_WIDTH           = 6,
    parameter int DATA_WIDTH           = 64,
    parameter int INIT_MEMORY_ON_RESET = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rq0_valid,
    output logic                  rq0_ready,
    input  logic                  rq0_we,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_data,
    input  logic [DATA_WIDTH-1:0] rq0_mask,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  rq1_valid,
    output logic                  rq1_ready,
    input  logic                  rq1_we,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_data,
    input  logic [DATA_WIDTH-1:0] rq1_mask,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_data_mask_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  init_busy
);

    // Handshake: a request transfers on a rising edge where rqN_valid & rqN_ready;
    // the requester holds valid and all fields stable until then. rspN has no
    // backpressure and ready never depends on it.

    logic                  open;
    logic                  rd_c0, rd_c1, wr_c0, wr_c1;
    logic                  rd_g0, rd_g1, wr_g0, wr_g1;
    logic                  rd_any, wr_any, collide, rd_ok;
    logic [ADDR_WIDTH-1:0] rd_addr_sel, wr_addr_sel;
    logic                  rd_prio, wr_prio, rd_pend, rd_owner;

    generate
        if (INIT_MEMORY_ON_RESET != 0) begin : g_init
            // MSB set means all 2^ADDR_WIDTH words have been zeroed by the RAM.
            logic [ADDR_WIDTH:0] init_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    init_cnt <= '0;
                else if (!init_cnt[ADDR_WIDTH])
                    init_cnt <= init_cnt + 1'b1;
            end
            assign init_busy = ~init_cnt[ADDR_WIDTH];
        end else begin : g_no_init
            assign init_busy = 1'b0;
        end
    endgenerate

    always_comb begin
        open  = rst_n & ~init_busy;
        rd_c0 = open & rq0_valid & ~rq0_we;
        rd_c1 = open & rq1_valid & ~rq1_we;
        wr_c0 = open & rq0_valid & rq0_we;
        wr_c1 = open & rq1_valid & rq1_we;

        rd_g0  = rd_c0 & (~rd_c1 | ~rd_prio);
        rd_g1  = rd_c1 & (~rd_c0 | rd_prio);
        wr_g0  = wr_c0 & (~wr_c1 | ~wr_prio);
        wr_g1  = wr_c1 & (~wr_c0 | wr_prio);
        rd_any = rd_g0 | rd_g1;
        wr_any = wr_g0 | wr_g1;

        rd_addr_sel = rd_g1 ? rq1_addr : rq0_addr;
        wr_addr_sel = wr_g1 ? rq1_addr : rq0_addr;

        // Same-address read is deferred a cycle so it observes the new data.
        collide = rd_any & wr_any & (rd_addr_sel == wr_addr_sel);
        rd_ok   = rd_any & ~collide;

        rq0_ready = (rd_g0 & ~collide) | wr_g0;
        rq1_ready = (rd_g1 & ~collide) | wr_g1;

        ram_rd_en        = rd_ok;
        ram_rd_addr      = rd_ok ? rd_addr_sel : '0;
        ram_wr_en        = wr_any;
        ram_wr_addr      = wr_any ? wr_addr_sel : '0;
        ram_data_in      = wr_g1 ? rq1_data : (wr_g0 ? rq0_data : '0);
        ram_data_mask_in = wr_g1 ? rq1_mask : (wr_g0 ? rq0_mask : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_prio  <= 1'b0;
            wr_prio  <= 1'b0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (rd_ok)
                rd_prio <= rd_g0;
            if (wr_any)
                wr_prio <= wr_g0;
            rd_pend <= rd_ok;
            if (rd_ok)
                rd_owner <= rd_g1;
        end
    end

    assign rsp0_valid = rd_pend & ~rd_owner;
    assign rsp1_valid = rd_pend & rd_owner;
    assign rsp0_data  = ram_data_out;
    assign rsp1_data  = ram_data_out;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Bench for dp_ram_arbiter: behavioural dp_ram, directed scenarios, then
// randomized traffic checked cycle by cycle against a rule-level model.
module tb_dp_ram_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          rq_valid [2];
    logic          rq_we    [2];
    logic [AW-1:0] rq_addr  [2];
    logic [DW-1:0] rq_data  [2];
    logic [DW-1:0] rq_mask  [2];

    logic          rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, init_busy;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [DW-1:0] ram_data_in, ram_data_mask_in, ram_data_out;

    dp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MEMORY_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq_valid[0]), .rq0_ready(rq0_ready), .rq0_we(rq_we[0]),
        .rq0_addr(rq_addr[0]), .rq0_data(rq_data[0]), .rq0_mask(rq_mask[0]),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rq1_valid(rq_valid[1]), .rq1_ready(rq1_ready), .rq1_we(rq_we[1]),
        .rq1_addr(rq_addr[1]), .rq1_data(rq_data[1]), .rq1_mask(rq_mask[1]),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_data_in(ram_data_in), .ram_data_mask_in(ram_data_mask_in),
        .ram_data_out(ram_data_out), .init_busy(init_busy)
    );

    // Behavioural dp_ram: registered read, masked write, zeroed on reset.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
            ram_data_out <= '0;
        end else begin
            if (ram_wr_en)
                ram_mem[ram_wr_addr] <= (ram_mem[ram_wr_addr] & ~ram_data_mask_in) |
                                        (ram_data_in & ram_data_mask_in);
            if (ram_rd_en)
                ram_data_out <= ram_mem[ram_rd_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int            rd_prio_m, wr_prio_m, init_left;
    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            own_q[$];
    logic          acc [2];

    task automatic model_reset();
        rd_prio_m = 0;
        wr_prio_m = 0;
        init_left = DEPTH;
        exp_q.delete();
        own_q.delete();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    endtask

    function automatic int pick(input bit is_wr, input int prio);
        bit c0, c1;
        c0 = rq_valid[0] && (rq_we[0] == is_wr);
        c1 = rq_valid[1] && (rq_we[1] == is_wr);
        if (c0 && c1) return prio;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    // One clock cycle: starts at a negedge with inputs applied, ends at the next negedge.
    task automatic step();
        int            rd_w, wr_w, own;
        bit            busy;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd, wm;
        #1;
        busy = (init_left > 0);
        rd_w = -1;
        wr_w = -1;
        if (!busy) begin
            rd_w = pick(1'b0, rd_prio_m);
            wr_w = pick(1'b1, wr_prio_m);
            if (rd_w >= 0 && wr_w >= 0 && rq_addr[rd_w] == rq_addr[wr_w]) rd_w = -1;
        end
        ra = (rd_w >= 0) ? rq_addr[rd_w] : '0;
        wa = (wr_w >= 0) ? rq_addr[wr_w] : '0;
        wd = (wr_w >= 0) ? rq_data[wr_w] : '0;
        wm = (wr_w >= 0) ? rq_mask[wr_w] : '0;
        check("init_busy", init_busy, busy);
        check("rq0_ready", rq0_ready, (rd_w == 0) || (wr_w == 0));
        check("rq1_ready", rq1_ready, (rd_w == 1) || (wr_w == 1));
        check("ram_rd_en", ram_rd_en, rd_w >= 0);
        check("ram_rd_addr", ram_rd_addr, ra);
        check("ram_wr_en", ram_wr_en, wr_w >= 0);
        check("ram_wr_addr", ram_wr_addr, wa);
        check("ram_data_in", ram_data_in, wd);
        check("ram_mask_in", ram_data_mask_in, wm);
        if (exp_q.size() > 0) begin
            own = own_q[0];
            check("rsp0_valid", rsp0_valid, own == 0);
            check("rsp1_valid", rsp1_valid, own == 1);
            check("rsp_data", (own == 1) ? rsp1_data : rsp0_data, exp_q[0]);
        end else begin
            check("rsp0_valid", rsp0_valid, 0);
            check("rsp1_valid", rsp1_valid, 0);
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(own_q.pop_front());
        end
        acc[0] = (rd_w == 0) || (wr_w == 0);
        acc[1] = (rd_w == 1) || (wr_w == 1);
        if (rd_w >= 0) begin
            exp_q.push_back(mdl_mem[ra]);
            own_q.push_back(rd_w);
            rd_prio_m = 1 - rd_w;
        end
        if (wr_w >= 0) begin
            mdl_mem[wa] = (mdl_mem[wa] & ~wm) | (wd & wm);
            wr_prio_m = 1 - wr_w;
        end
        if (busy) init_left--;
        @(negedge clk);
    endtask

    task automatic req(input int n, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
        rq_valid[n] = 1'b1;
        rq_we[n]    = we;
        rq_addr[n]  = a;
        rq_data[n]  = d;
        rq_mask[n]  = m;
    endtask

    task automatic idle(input int n);
        rq_valid[n] = 1'b0;
        rq_we[n]    = 1'b0;
        rq_addr[n]  = '0;
        rq_data[n]  = '0;
        rq_mask[n]  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, w;
        bit  pending [2];
        idle(0);
        idle(1);
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        model_reset();

        // Reset values, with rq0 read already asserted
        req(0, 1'b0, 4'd0, 8'h00, 8'h00);
        #1;
        check("rst_rq0_ready", rq0_ready, 0);
        check("rst_rq1_ready", rq1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_init_busy", init_busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Init blackout: first grant in cycle 17, response of 0 in cycle 18
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!acc[0] && cyc < 40);
        check("init_grant_cycle", cyc, 17);
        idle(0);
        #1 check("init_rsp_data", rsp0_data, 8'h00);
        step();

        // Write then read from the other requester
        req(0, 1'b1, 4'd5, 8'hA5, 8'hFF);
        step();
        check("wr5_acc", acc[0], 1);
        idle(0);
        req(1, 1'b0, 4'd5, 8'h00, 8'h00);
        step();
        idle(1);
        #1;
        check("wr_rd_rsp1_valid", rsp1_valid, 1);
        check("wr_rd_rsp0_valid", rsp0_valid, 0);
        check("wr_rd_rsp1_data", rsp1_data, 8'hA5);
        step();

        // Round-robin reads, both requesters continuously valid
        req(0, 1'b0, 4'd0, 8'h00, 8'h00);
        req(1, 1'b0, 4'd1, 8'h00, 8'h00);
        for (int g = 0; g < 6; g++) begin
            step();
            w = acc[0] ? 0 : (acc[1] ? 1 : -1);
            check("rr_order", w, g % 2);
            if (w >= 0) rq_addr[w] = 4'($urandom_range(0, DEPTH - 1));
        end
        idle(0);
        idle(1);
        step();

        // Collision: write wins, read deferred one cycle and sees new data
        req(0, 1'b1, 4'd3, 8'h11, 8'hFF);
        req(1, 1'b0, 4'd3, 8'h00, 8'h00);
        step();
        check("coll_wr_acc", acc[0], 1);
        check("coll_rd_held", acc[1], 0);
        idle(0);
        step();
        check("coll_rd_acc", acc[1], 1);
        idle(1);
        #1 check("coll_rsp_data", rsp1_data, 8'h11);
        step();

        // Parallel read + masked write in one cycle
        req(0, 1'b0, 4'd2, 8'h00, 8'h00);
        req(1, 1'b1, 4'd7, 8'hFF, 8'h0F);
        step();
        check("par_rd_acc", acc[0], 1);
        check("par_wr_acc", acc[1], 1);
        idle(1);
        req(0, 1'b0, 4'd7, 8'h00, 8'h00);
        step();
        idle(0);
        #1 check("mask_rd_data", rsp0_data, 8'h0F);
        step();

        // Async reset while a response is in flight
        req(0, 1'b1, 4'd9, 8'h3C, 8'hFF);
        step();
        req(0, 1'b0, 4'd1, 8'h00, 8'h00);
        step();
        idle(0);
        #1 check("pre_rst_rsp0_valid", rsp0_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rsp0_valid", rsp0_valid, 0);
        check("arst_rsp1_valid", rsp1_valid, 0);
        check("arst_rd_en", ram_rd_en, 0);
        check("arst_init_busy", init_busy, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        req(0, 1'b0, 4'd4, 8'h00, 8'h00);
        req(1, 1'b0, 4'd6, 8'h00, 8'h00);
        step();
        check("rd_prio_after_rst", acc[0], 1);
        req(0, 1'b1, 4'd4, 8'h5A, 8'hFF);
        req(1, 1'b1, 4'd6, 8'hC3, 8'hFF);
        step();
        check("wr_prio_after_rst", acc[0], 1);
        idle(0);
        idle(1);
        step();
        step();

        // Randomized traffic on a narrow address range to force contention
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pending[n]) begin
                    if ($urandom_range(0, 9) < 7)
                        req(n, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                            8'($urandom), 8'($urandom));
                    else
                        idle(n);
                end
            end
            step();
            for (int n = 0; n < 2; n++) pending[n] = rq_valid[n] && !acc[n];
        end
        idle(0);
        idle(1);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
